// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Definitions shared by the UART transmit and receive sides.
//   - uart_state_e      : frame-sequencer state encoding
//   - DATA_BITS         : payload bits per frame
//   - FRAME_BITS        : total line bits per frame (start + data [+ parity] + stop)
//   - uart_clks_per_bit : clock cycles per line bit for a clock/baud pair
// Optional feature macro: UART_TX_PARITY_EN (adds the even-parity bit and the
// PARITY state; without it neither exists).
// -----------------------------------------------------------------------------
package uart_pkg;

   localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_DONE   = 3'd5
   } uart_state_e;
`else
   localparam int FRAME_BITS = 10;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd4,
      ST_DONE   = 3'd5
   } uart_state_e;
`endif

   // Integer division: any fractional remainder is dropped.
   function automatic int uart_clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// -----------------------------------------------------------------------------
// uart_baud_counter
// Free-running bit-period counter. It counts 0 .. CLKS_PER_BIT-1 and wraps,
// raising tick_o during the last cycle of every bit period.
// Ports:
//   clk_i    : clock
//   rst_ni   : asynchronous active-low reset
//   clear_i  : hold the count at zero (asserted while no frame is running, so
//              the first bit of a new frame starts at count 0)
//   tick_o   : one-cycle bit-end tick
// -----------------------------------------------------------------------------
module uart_baud_counter #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   output logic tick_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i || tick_o) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_transmitter.sv
// -----------------------------------------------------------------------------
// uart_transmitter
// 8N1 UART transmitter (8E1 when UART_TX_PARITY_EN is defined).
// Ports:
//   clkIN    : clock, all state updates on its rising edge
//   nResetIN : asynchronous active-low reset
//   dataIN   : byte to send, captured only when a frame is accepted
//   sendIN   : level send request
//   txOUT    : serial line, idle high (registered)
//   busyOUT  : high from acceptance through the end of the stop bit
//   doneOUT  : completion acknowledge, held until sendIN is seen low
// Valid/ready: a frame is accepted on the rising edge where the block is in
// IDLE and sendIN is high; busyOUT acts as the inverse of ready. After the
// stop bit the block waits in DONE until sendIN is low, so a held request
// never launches a second frame.
// Optional feature macro: UART_TX_PARITY_EN (even-parity bit before stop).
// -----------------------------------------------------------------------------
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 115200
) (
   input  logic       clkIN,
   input  logic       nResetIN,
   input  logic [7:0] dataIN,
   input  logic       sendIN,
   output logic       txOUT,
   output logic       busyOUT,
   output logic       doneOUT
);

   localparam int CLKS_PER_BIT = uart_clks_per_bit(CLK_FREQ, BAUD);
   localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("uart_transmitter: CLK_FREQ/BAUD must be at least 2");
   end

   uart_state_e state_q, state_d;
   logic [7:0]  shift_q, shift_d;
   logic [2:0]  bit_idx_q, bit_idx_d;
   logic        tx_q, tx_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        bit_tick;
   logic        baud_clear;
`ifdef UART_TX_PARITY_EN
   logic        parity_q, parity_d;
`endif

   // Counter is parked at zero whenever no frame is on the line.
   assign baud_clear = (state_q == ST_IDLE) || (state_q == ST_DONE);

   uart_baud_counter #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_baud (
      .clk_i  (clkIN),
      .rst_ni (nResetIN),
      .clear_i(baud_clear),
      .tick_o (bit_tick)
   );

   // tx_d is the value the line takes after the edge, so every transition
   // loads the first bit of the state being entered.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_idx_d = bit_idx_q;
      tx_d      = tx_q;
      busy_d    = busy_q;
      done_d    = done_q;
`ifdef UART_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      case (state_q)
         ST_IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            done_d = 1'b0;
            if (sendIN) begin
               state_d   = ST_START;
               shift_d   = dataIN;
               bit_idx_d = '0;
               tx_d      = 1'b0;
               busy_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
               parity_d  = ^dataIN;
`endif
            end
         end
         ST_START: begin
            if (bit_tick) begin
               state_d = ST_DATA;
               tx_d    = shift_q[0];
            end
         end
         ST_DATA: begin
            if (bit_tick) begin
               if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
                  tx_d    = parity_q;
`else
                  state_d = ST_STOP;
                  tx_d    = 1'b1;
`endif
               end else begin
                  shift_d   = shift_q >> 1;
                  tx_d      = shift_q[1];
                  bit_idx_d = bit_idx_q + 3'd1;
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_tick) begin
               state_d = ST_STOP;
               tx_d    = 1'b1;
            end
         end
`endif
         ST_STOP: begin
            if (bit_tick) begin
               state_d = ST_DONE;
               tx_d    = 1'b1;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end
         end
         ST_DONE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            done_d = 1'b1;
            if (!sendIN) begin
               state_d = ST_IDLE;
               done_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clkIN or negedge nResetIN) begin
      if (!nResetIN) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_idx_q <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_idx_q <= bit_idx_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

`ifdef UART_TX_PARITY_EN
   always_ff @(posedge clkIN or negedge nResetIN) begin
      if (!nResetIN) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end
`endif

   assign txOUT   = tx_q;
   assign busyOUT = busy_q;
   assign doneOUT = done_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// -----------------------------------------------------------------------------
// tb_uart_transmitter
// Directed bench for uart_transmitter at default parameters (434 clocks/bit).
// Expected frames are hand-written bit vectors, bit k = k-th bit on the line.
// -----------------------------------------------------------------------------
module tb_uart_transmitter;

   localparam int CPB  = 434;
   localparam int HALF = CPB / 2;

`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
   // {stop, parity, data[7:0], start}
   localparam logic [10:0] F55 = 11'b1_0_01010101_0;
   localparam logic [10:0] FA5 = 11'b1_0_10100101_0;
   localparam logic [10:0] F3C = 11'b1_0_00111100_0;
   localparam logic [10:0] F07 = 11'b1_1_00000111_0;
`else
   localparam int NB = 10;
   // {pad, stop, data[7:0], start}
   localparam logic [10:0] F55 = 11'b0_1_01010101_0;
   localparam logic [10:0] FA5 = 11'b0_1_10100101_0;
   localparam logic [10:0] F3C = 11'b0_1_00111100_0;
   localparam logic [10:0] F07 = 11'b0_1_00000111_0;
`endif

   logic       clk;
   logic       n_reset;
   logic [7:0] data;
   logic       send;
   logic       tx;
   logic       busy;
   logic       done;

   int checks   = 0;
   int failures = 0;

   uart_transmitter dut (
      .clkIN   (clk),
      .nResetIN(n_reset),
      .dataIN  (data),
      .sendIN  (send),
      .txOUT   (tx),
      .busyOUT (busy),
      .doneOUT (done)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // driver / checker tasks
   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered just after the accepting edge (offset 0 of the start bit).
   // Leaves just after the edge that ends the stop bit.
   task automatic check_frame(input logic [10:0] exp_bits, input string tag);
      for (int k = 0; k < NB; k++) begin
         wait_cycles(HALF);
         chk($sformatf("%s_bit%0d_mid", tag, k), tx, exp_bits[k]);
         wait_cycles(CPB - HALF - 1);
         chk($sformatf("%s_bit%0d_end", tag, k), tx, exp_bits[k]);
         chk($sformatf("%s_bit%0d_busy", tag, k), busy, 1);
         chk($sformatf("%s_bit%0d_done", tag, k), done, 0);
         wait_cycles(1);
      end
      chk({tag, "_done_rise"}, done, 1);
      chk({tag, "_busy_fall"}, busy, 0);
      chk({tag, "_tx_idle"}, tx, 1);
   endtask

   initial begin
      n_reset = 1'b0;
      send    = 1'b0;
      data    = 8'h00;

      // reset state
      wait_cycles(3);
      chk("rst_tx", tx, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      n_reset = 1'b1;
      wait_cycles(2);
      chk("idle_tx", tx, 1);

      // frame 0x55 with send held high
      data = 8'h55;
      send = 1'b1;
      chk("a_pre_tx", tx, 1);
      chk("a_pre_busy", busy, 0);
      wait_cycles(1);
      chk("a_start_tx", tx, 0);
      chk("a_start_busy", busy, 1);
      check_frame(F55, "a55");

      // send still high: done holds, no second frame
      wait_cycles(50);
      chk("hold_done", done, 1);
      chk("hold_busy", busy, 0);
      chk("hold_tx", tx, 1);
      send = 1'b0;
      wait_cycles(1);
      chk("hold_release_done", done, 0);
      chk("hold_release_tx", tx, 1);

      // frame 0xA5
      data = 8'hA5;
      send = 1'b1;
      wait_cycles(1);
      chk("b_start_tx", tx, 0);
      check_frame(FA5, "bA5");
      send = 1'b0;
      wait_cycles(1);
      chk("b_release_done", done, 0);

      // one-cycle request, data changed after acceptance
      data = 8'h3C;
      send = 1'b1;
      wait_cycles(1);
      send = 1'b0;
      data = 8'hFF;
      chk("c_start_tx", tx, 0);
      check_frame(F3C, "c3C");
      wait_cycles(1);
      chk("c_done_pulse_end", done, 0);
      chk("c_idle_tx", tx, 1);

      // reset at cycle 2000 of a frame (data bit 3 of 0x07 = 0 on the line)
      data = 8'h07;
      send = 1'b1;
      wait_cycles(1);
      send = 1'b0;
      wait_cycles(1999);
      chk("d_pre_rst_tx", tx, 0);
      chk("d_pre_rst_busy", busy, 1);
      #2;
      n_reset = 1'b0;
      #1;
      chk("d_async_tx", tx, 1);
      chk("d_async_busy", busy, 0);
      chk("d_async_done", done, 0);
      wait_cycles(3);
      chk("d_hold_tx", tx, 1);

      // release with request already high: starts on the first edge
      n_reset = 1'b1;
      send    = 1'b1;
      data    = 8'h07;
      wait_cycles(1);
      chk("e_start_tx", tx, 0);
      chk("e_start_busy", busy, 1);
      check_frame(F07, "e07");

      // back-to-back: drop send for one cycle in DONE, then re-request
      send = 1'b0;
      wait_cycles(1);
      chk("f_gap1_tx", tx, 1);
      chk("f_gap1_done", done, 0);
      chk("f_gap1_busy", busy, 0);
      data = 8'h55;
      send = 1'b1;
      wait_cycles(1);
      chk("f_start_tx", tx, 0);
      chk("f_start_busy", busy, 1);
      check_frame(F55, "f55");
      send = 1'b0;
      wait_cycles(1);
      chk("f_release_done", done, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
